// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin scheduler in front of the shared 8-bit CSA
// multiplier. Two requesters compete. The winning operands are registered onto
// the multiplier inputs and held for SETTLE_CYCLES edges, so the combinational
// CSA/CLA path can settle. Pr/OF are then captured and returned on one tagged
// response channel. The next operation is accepted only after the response
// handshake, so the multiplier inputs never move while a result is pending.
module mul_share_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic       req0_signed,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic       req1_signed,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic       resp_id,
   output logic [7:0] resp_prod,
   output logic       resp_of,
   output logic [7:0] mul_a,
   output logic [7:0] mul_b,
   output logic       mul_cont,
   input  logic [7:0] mul_pr,
   input  logic       mul_of
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             last_id;   // last granted requester; reset to 1 so req0 wins the first tie
   logic             op_id;     // owner of the in-flight operation
   logic             grant_id;
   logic             grant_any;
   logic             accept;

   // Round-robin pick: a lone requester always wins, and a tie goes to the one not served last.
   always_comb begin
      grant_any = req0_valid | req1_valid;
      grant_id  = 1'b0;
      if (req0_valid & req1_valid)
         grant_id = ~last_id;
      else if (req1_valid)
         grant_id = 1'b1;
   end

   // Next state and handshake readies. Readies are forced low while rst is asserted.
   always_comb begin
      state_nx   = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (grant_any && !rst) begin
               accept     = 1'b1;
               req0_ready = ~grant_id;
               req1_ready = grant_id;
               state_nx   = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt == '0)
               state_nx = RESP;
         end
         RESP: begin
            if (resp_ready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Operand latch, settle countdown, result capture and response handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         last_id    <= 1'b1;
         op_id      <= 1'b0;
         mul_a      <= 8'h00;
         mul_b      <= 8'h00;
         mul_cont   <= 1'b0;
         resp_valid <= 1'b0;
         resp_id    <= 1'b0;
         resp_prod  <= 8'h00;
         resp_of    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  mul_a    <= grant_id ? req1_a      : req0_a;
                  mul_b    <= grant_id ? req1_b      : req0_b;
                  mul_cont <= grant_id ? req1_signed : req0_signed;
                  op_id    <= grant_id;
                  last_id  <= grant_id;
                  cnt      <= CNT_W'(SETTLE_CYCLES - 1);
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  resp_prod  <= mul_pr;
                  resp_of    <= mul_of;
                  resp_id    <= op_id;
                  resp_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               // Data registers keep their last value after the handshake.
               if (resp_ready)
                  resp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
